// File: rtl/guess_pkg.sv
// Shared encodings for the number-guessing game: FSM states, LCD message
// codes and keypad codes, plus decode helpers used by the controller.
package guess_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTRY     = 3'd1,
    S_COMPARE   = 3'd2,
    S_SHOW_UP   = 3'd3,
    S_SHOW_DOWN = 3'd4,
    S_CORRECT   = 3'd5,
    S_FAILED    = 3'd6,
    S_RETRY     = 3'd7
  } state_t;

  localparam logic [2:0] MSG_CORRECT   = 3'b000;
  localparam logic [2:0] MSG_FAILED    = 3'b001;
  localparam logic [2:0] MSG_UP        = 3'b010;
  localparam logic [2:0] MSG_DOWN      = 3'b011;
  localparam logic [2:0] MSG_RETRY     = 3'b100;
  localparam logic [2:0] MSG_START     = 3'b101;
  localparam logic [2:0] MSG_ENTER_NUM = 3'b110;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  function automatic logic [2:0] state_msg(input state_t s);
    case (s)
      S_IDLE:      state_msg = MSG_START;
      S_ENTRY,
      S_COMPARE:   state_msg = MSG_ENTER_NUM;
      S_SHOW_UP:   state_msg = MSG_UP;
      S_SHOW_DOWN: state_msg = MSG_DOWN;
      S_CORRECT:   state_msg = MSG_CORRECT;
      S_FAILED:    state_msg = MSG_FAILED;
      default:     state_msg = MSG_RETRY;
    endcase
  endfunction

  function automatic logic state_busy(input state_t s);
    state_busy = (s == S_COMPARE) || (s == S_SHOW_UP) || (s == S_SHOW_DOWN) ||
                 (s == S_CORRECT) || (s == S_FAILED);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Message hold timer: start (re)arms the count from 0; done pulses in the
// HOLD_CYCLES-th cycle after start, so the owning state lasts exactly that long.
module hold_timer #(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          run;

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      if (done) begin
        cnt <= '0;
        run <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: keypad entry of a 0..99 guess against a
// secret sampled from a free-running counter, with timed LCD messages.
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int MAX_TRIES   = 7,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] output_command,
  output logic [3:0] tries_left,
  output logic [6:0] guess_value,
  output logic       busy
);

  state_t     state;
  logic [6:0] secret_ctr;
  logic [6:0] secret;
  logic [1:0] digit_cnt;
  logic       hold_done;

  logic       is_digit;
  logic [3:0] tries_dec;

  assign is_digit       = (key_code <= 4'd9);
  assign tries_dec      = tries_left - 4'd1;
  assign output_command = state_msg(state);
  assign busy           = state_busy(state);

  // Every hold state is entered from COMPARE, so that is where the timer is armed.
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk    (clk),
    .resetn (resetn),
    .start  (state == S_COMPARE),
    .done   (hold_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) secret_ctr <= '0;
    else         secret_ctr <= (secret_ctr == 7'd99) ? 7'd0 : secret_ctr + 7'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      secret      <= '0;
      tries_left  <= '0;
      guess_value <= '0;
      digit_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (key_valid) begin
          secret      <= secret_ctr;
          tries_left  <= 4'(MAX_TRIES);
          guess_value <= '0;
          digit_cnt   <= '0;
          state       <= S_ENTRY;
        end
        S_ENTRY: if (key_valid) begin
          if (is_digit) begin
            // Keep only the last two digits typed.
            guess_value <= (guess_value % 7'd10) * 7'd10 + {3'b000, key_code};
            digit_cnt   <= (digit_cnt == 2'd2) ? 2'd2 : digit_cnt + 2'd1;
          end else if (key_code == KEY_CLEAR) begin
            guess_value <= '0;
            digit_cnt   <= '0;
          end else if (key_code == KEY_ENTER && digit_cnt != 2'd0) begin
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          tries_left <= tries_dec;
          if (guess_value == secret)  state <= S_CORRECT;
          else if (tries_dec == 4'd0) state <= S_FAILED;
          else if (guess_value < secret) state <= S_SHOW_UP;
          else                        state <= S_SHOW_DOWN;
        end
        S_SHOW_UP, S_SHOW_DOWN: if (hold_done) begin
          guess_value <= '0;
          digit_cnt   <= '0;
          state       <= S_ENTRY;
        end
        S_CORRECT, S_FAILED: if (hold_done) state <= S_RETRY;
        S_RETRY: if (key_valid) begin
          if (key_code == KEY_ENTER) begin
            secret      <= secret_ctr;
            tries_left  <= 4'(MAX_TRIES);
            guess_value <= '0;
            digit_cnt   <= '0;
            state       <= S_ENTRY;
          end else if (key_code == KEY_CLEAR) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Bench for guess_game_ctrl: directed scenarios plus random rounds checked
// against a game-level model (secret = edges since reset mod 100).
module tb_guess_game_ctrl;
  import guess_pkg::*;

  localparam int TRIES = 3;
  localparam int HOLD  = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [2:0] output_command;
  logic [3:0] tries_left;
  logic [6:0] guess_value;
  logic       busy;

  guess_game_ctrl #(.MAX_TRIES(TRIES), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .output_command (output_command),
    .tries_left     (tries_left),
    .guess_value    (guess_value),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edges = 0;
  int m_secret = 0;
  int m_tries  = 0;
  bit in_retry = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic press(input int k);
    key_valid = 1'b1;
    key_code  = 4'(k);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic type_num(input int v);
    press(v / 10);
    press(v % 10);
    chk("typed_value", guess_value, v);
  endtask

  task automatic type_random(output int v);
    int n;
    n = $urandom_range(1, 3);
    v = 0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = $urandom_range(0, 9);
      press(d);
      v = (v % 10) * 10 + d;
    end
    if ($urandom_range(0, 3) == 0) begin
      press(KEY_CLEAR);
      chk("rand_clear", guess_value, 0);
      v = $urandom_range(0, 9);
      press(v);
    end
    chk("rand_typed", guess_value, v);
  endtask

  // Submit the current entry and follow the full response through its hold.
  task automatic submit(input int g);
    int exp_cmd;
    m_tries--;
    if (g == m_secret)      exp_cmd = 0;
    else if (m_tries == 0)  exp_cmd = 1;
    else if (g < m_secret)  exp_cmd = 2;
    else                    exp_cmd = 3;
    press(KEY_ENTER);
    chk("compare_cmd", output_command, 6);
    chk("compare_busy", busy, 1);
    tick();
    chk("hold_tries", tries_left, m_tries);
    for (int i = 0; i < HOLD; i++) begin
      chk("hold_cmd", output_command, exp_cmd);
      chk("hold_busy", busy, 1);
      if ($urandom_range(0, 1) == 1) begin
        key_valid = 1'b1;
        key_code  = 4'($urandom_range(0, 15));
      end
      tick();
      key_valid = 1'b0;
    end
    if (exp_cmd <= 1) begin
      in_retry = 1;
      chk("after_hold_retry", output_command, 4);
    end else begin
      chk("after_hold_entry", output_command, 6);
      chk("after_hold_guess", guess_value, 0);
      chk("after_hold_tries", tries_left, m_tries);
    end
    chk("after_hold_busy", busy, 0);
  endtask

  // From RETRY: align the free-running counter (or wait randomly) and restart.
  task automatic new_round(input int align);
    if (align >= 0) begin
      while (edges % 100 != align) tick();
    end else begin
      repeat ($urandom_range(0, 150)) tick();
    end
    m_secret = edges % 100;
    press(KEY_ENTER);
    m_tries  = TRIES;
    in_retry = 0;
    chk("round_cmd", output_command, 6);
    chk("round_tries", tries_left, TRIES);
    chk("round_guess", guess_value, 0);
  endtask

  initial begin
    int g;

    // reset state
    #2;
    chk("rst_cmd", output_command, 5);
    chk("rst_tries", tries_left, 0);
    chk("rst_guess", guess_value, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #3;
    resetn = 1'b1;
    edges  = 0;

    // first key after 41 edges latches secret 41
    repeat (41) tick();
    m_secret = edges % 100;
    press(5);
    m_tries = TRIES;
    chk("idle_secret_align", m_secret, 41);
    chk("start_cmd", output_command, 6);
    chk("start_tries", tries_left, TRIES);
    chk("start_guess", guess_value, 0);

    type_num(20);
    submit(20);

    // ENTER with no digits is ignored; CLEAR empties the entry
    press(KEY_ENTER);
    chk("empty_enter_cmd", output_command, 6);
    chk("empty_enter_busy", busy, 0);
    press(9);
    chk("nine", guess_value, 9);
    press(KEY_CLEAR);
    chk("clear", guess_value, 0);
    press(KEY_ENTER);
    chk("enter_after_clear", busy, 0);

    press(7); press(4); press(1);
    chk("last_two_digits", guess_value, 41);
    submit(41);

    press(3);
    chk("retry_ignore", output_command, 4);

    // three wrong guesses: down, up, then failed on the last try
    new_round(41);
    type_num(50); submit(50);
    type_num(30); submit(30);
    type_num(99); submit(99);

    press(KEY_CLEAR);
    chk("retry_clear_idle", output_command, 5);

    repeat ($urandom_range(0, 120)) tick();
    m_secret = edges % 100;
    press($urandom_range(0, 15));
    m_tries = TRIES;
    in_retry = 0;
    chk("idle_rand_cmd", output_command, 6);
    chk("idle_rand_tries", tries_left, TRIES);

    for (int r = 0; r < 5; r++) begin
      while (!in_retry) begin
        type_random(g);
        submit(g);
      end
      new_round(-1);
    end

    // correct guess on the last try wins
    type_num((m_secret + 1) % 100); submit((m_secret + 1) % 100);
    type_num((m_secret + 2) % 100); submit((m_secret + 2) % 100);
    type_num(m_secret);             submit(m_secret);
    chk("last_try_correct_flag", int'(in_retry), 1);

    // asynchronous reset in the middle of SHOW_DOWN
    new_round(41);
    type_num(99);
    press(KEY_ENTER);
    tick();
    chk("pre_reset_down", output_command, 3);
    repeat (3) tick();
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_cmd", output_command, 5);
    chk("async_rst_tries", tries_left, 0);
    chk("async_rst_guess", guess_value, 0);
    chk("async_rst_busy", busy, 0);
    #3;
    resetn = 1'b1;
    edges  = 0;
    tick();
    chk("post_rst_idle", output_command, 5);
    while (edges != 17) tick();
    m_secret = edges % 100;
    press(KEY_ENTER);
    m_tries = TRIES;
    in_retry = 0;
    chk("post_rst_start", output_command, 6);
    chk("post_rst_tries", tries_left, TRIES);
    type_num(17);
    submit(17);
    chk("post_rst_win", int'(in_retry), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 Parameter MAX_TRIES, default 7: guesses allowed per round, range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1024: clk cycles each transient message is held on the LCD.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 key_valid  input  1  one-cycle pulse qualifying key_code.
REQ-006 key_code  input  4  key value: 0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC-4'hF ignored.
REQ-007 output_command  output  3  message code to the text LCD driver: 000 correct, 001 failed, 010 up, 011 down, 100 retry, 101 start, 110 enter number.
REQ-008 tries_left  output  4  guesses remaining in the current round.
REQ-009 guess_value  output  7  decimal value currently entered, 0..99.
REQ-010 busy  output  1  high while key input is being ignored (COMPARE, SHOW_UP, SHOW_DOWN, CORRECT, FAILED).

Function
REQ-011 The block SHALL be a Moore FSM with states IDLE, ENTRY, COMPARE, SHOW_UP, SHOW_DOWN, CORRECT, FAILED and RETRY.
REQ-012 output_command SHALL be decoded from the state register only, as follows:
- IDLE=101, ENTRY=110, COMPARE=110, SHOW_UP=010, SHOW_DOWN=011, CORRECT=000, FAILED=001, RETRY=100.
REQ-013 Free-running counter secret_ctr SHALL count 0..99 each cycle and wrap 99->0; it resets to 0.
REQ-014 IDLE: any key_valid SHALL latch secret_ctr (pre-increment value) as the secret, load tries_left=MAX_TRIES, clear the guess, and go to ENTRY.
REQ-015 ENTRY, digit key: guess_value <= (guess_value mod 10)*10 + digit; digit count saturates at 2.
- Only the last two digits are kept.
REQ-016 ENTRY, CLEAR: guess_value and digit count SHALL go to 0.
REQ-017 ENTRY, ENTER with digit count 0: ignored; with digit count >=1: go to COMPARE.
REQ-018 COMPARE SHALL last exactly one cycle, decrement tries_left, and branch as follows:
- guess==secret -> CORRECT;
- else post-decrement tries_left==0 -> FAILED;
- else guess<secret -> SHOW_UP;
- else -> SHOW_DOWN.
REQ-019 A correct guess on the last try SHALL go to CORRECT, not FAILED.
REQ-020 SHOW_UP/SHOW_DOWN SHALL last exactly HOLD_CYCLES cycles, then go to ENTRY with guess_value and digit count cleared.
REQ-021 CORRECT/FAILED SHALL last exactly HOLD_CYCLES cycles, then go to RETRY.
REQ-022 RETRY has three key responses:
- ENTER: latch a new secret, load tries_left=MAX_TRIES, clear the guess, go to ENTRY;
- CLEAR: go to IDLE;
- other keys: ignored.
REQ-023 key_valid while busy=1 SHALL be discarded, not queued.
REQ-024 The hold counter SHALL restart from 0 on every entry into a hold state.

Reset
REQ-025 Asserting resetn low at any time, including mid-hold or in COMPARE, SHALL immediately force:
- state=IDLE, output_command=101;
- tries_left=0, guess_value=0, busy=0;
- secret_ctr=0, hold counter=0, digit count=0.
REQ-026 The first rising clk edge after resetn deasserts SHALL evaluate IDLE normally.

Structure
REQ-027 Shared package guess_pkg SHALL hold:
- the state encoding;
- the seven 3-bit message codes, which are also used by the LCD driver's caller;
- the key codes KEY_ENTER=4'hA and KEY_CLEAR=4'hB.
REQ-028 One sub-module hold_timer SHALL be used: inputs start/clk/resetn, output done pulsed after HOLD_CYCLES cycles.
REQ-029 The comparison and the decimal shift SHALL be plain 7-bit unsigned arithmetic; the shift never exceeds 99.

Verification (MAX_TRIES=3, HOLD_CYCLES=8)
REQ-030 Reset, then key 5 after 41 edges -> secret 41, state ENTRY, cmd 110, tries_left 3.
REQ-031 Secret 41, enter 2,0,ENTER -> one cycle of 110, then 010 for exactly 8 cycles, then 110 with guess_value 0, tries_left 2.
REQ-032 Secret 41, enter 7,4,1,ENTER -> guess_value 41, cmd 000 for 8 cycles, then 100.
REQ-033 Secret 41, three wrong guesses (50, 30, 99) -> 011, 010, then 001 (not 011) on the third, then 100.
REQ-034 Key pulses during a hold state and ENTER with no digits -> no state change; CLEAR after 9 -> guess_value 0.
REQ-035 resetn low mid-SHOW_DOWN -> cmd 101 and tries_left 0 asynchronously; RETRY+CLEAR -> IDLE/101; RETRY+ENTER -> ENTRY with tries_left 3.
